// File: rtl/adder_ring_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : adder_ring_sequencer
// Brief    : Sequences ring-oscillator delay measurements of an instrumented
//            adder: settle, gated run, drain, accumulate over repeated runs.
// Revision : 1.0 - initial release
// ============================================================================
module adder_ring_sequencer #(
    parameter int W      = 32,
    parameter int CW     = 32,
    parameter int GW     = 16,
    parameter int SETTLE = 4,
    parameter int DRAIN  = 3
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          start,
    input  logic          abort,
    input  logic [W-1:0]  a_cfg,
    input  logic [W-1:0]  b_cfg,
    input  logic [W-1:0]  ext_mask_cfg,
    input  logic [W-1:0]  ring_mask_cfg,
    input  logic [GW-1:0] gate_cycles,
    input  logic [7:0]    repeats,
    output logic [W-1:0]  adder_a,
    output logic [W-1:0]  adder_b,
    output logic [W-1:0]  adder_ext_bit,
    output logic [W-1:0]  adder_ring_bit,
    output logic          ring_en,
    output logic          cnt_clr,
    input  logic [CW-1:0] cnt_val,
    input  logic [W-1:0]  sum_in,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] result_count,
    output logic [W-1:0]  result_sum,
    output logic          overflow
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_ACCUM = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [GW-1:0] C_SETTLE_LAST = GW'(SETTLE - 1);
    localparam logic [GW-1:0] C_DRAIN_LAST  = GW'(DRAIN - 1);

    state_t        state_q;
    logic [GW-1:0] phase_q;
    logic [GW-1:0] gate_q;
    logic [7:0]    runs_q;
    logic [CW-1:0] acc_q;
    logic [CW:0]   acc_sum_d;
    logic [CW-1:0] acc_d;

    // Saturating accumulate; the carry out flags saturation.
    always_comb begin
        acc_sum_d = {1'b0, acc_q} + {1'b0, cnt_val};
        acc_d     = acc_sum_d[CW] ? {CW{1'b1}} : acc_sum_d[CW-1:0];
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q        <= S_IDLE;
            phase_q        <= '0;
            gate_q         <= '0;
            runs_q         <= '0;
            acc_q          <= '0;
            adder_a        <= '0;
            adder_b        <= '0;
            adder_ext_bit  <= '0;
            adder_ring_bit <= '0;
            ring_en        <= 1'b0;
            cnt_clr        <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            result_count   <= '0;
            result_sum     <= '0;
            overflow       <= 1'b0;
        end else if (abort) begin
            state_q <= S_IDLE;
            ring_en <= 1'b0;
            cnt_clr <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        adder_a        <= a_cfg;
                        adder_b        <= b_cfg;
                        adder_ext_bit  <= ext_mask_cfg;
                        adder_ring_bit <= ring_mask_cfg;
                        gate_q         <= (gate_cycles == '0) ? GW'(1) : gate_cycles;
                        runs_q         <= (repeats == 8'd0) ? 8'd1 : repeats;
                        acc_q          <= '0;
                        overflow       <= 1'b0;
                        phase_q        <= C_SETTLE_LAST;
                        cnt_clr        <= 1'b1;
                        busy           <= 1'b1;
                        state_q        <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (phase_q == '0) begin
                        phase_q <= gate_q - GW'(1);
                        cnt_clr <= 1'b0;
                        ring_en <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        phase_q <= phase_q - GW'(1);
                    end
                end
                S_RUN: begin
                    if (phase_q == '0) begin
                        phase_q <= C_DRAIN_LAST;
                        ring_en <= 1'b0;
                        state_q <= S_DRAIN;
                    end else begin
                        phase_q <= phase_q - GW'(1);
                    end
                end
                S_DRAIN: begin
                    if (phase_q == '0) begin
                        state_q <= S_ACCUM;
                    end else begin
                        phase_q <= phase_q - GW'(1);
                    end
                end
                S_ACCUM: begin
                    acc_q      <= acc_d;
                    result_sum <= sum_in;
                    runs_q     <= runs_q - 8'd1;
                    if (acc_sum_d[CW]) begin
                        overflow <= 1'b1;
                    end
                    // result_count is loaded on entry to DONE so it is valid with the pulse.
                    if (runs_q == 8'd1) begin
                        result_count <= acc_d;
                        done         <= 1'b1;
                        busy         <= 1'b0;
                        state_q      <= S_DONE;
                    end else begin
                        phase_q <= C_SETTLE_LAST;
                        cnt_clr <= 1'b1;
                        state_q <= S_SETUP;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    ring_en <= 1'b0;
                    cnt_clr <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
